// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  function automatic int tag_width(input int addr_w, input int index_w, input int word_sel_w);
    return addr_w - index_w - word_sel_w - 2;
  endfunction

  function automatic int line_width(input int word_sel_w);
    return 32 << word_sel_w;
  endfunction

  // Bit offset of a 32-bit word inside a line, given its word-select value.
  function automatic int word_lsb(input int sel);
    return sel * 32;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, combinational read port, single fill port.
module icache_way #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 23,
  parameter int LINE_WIDTH  = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [TAG_WIDTH-1:0]   rd_tag,
  output logic                   hit,
  output logic                   valid,
  output logic [LINE_WIDTH-1:0]  line,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [LINE_WIDTH-1:0]  wr_line
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [LINE_WIDTH-1:0] data_q [SETS];

  always_ff @(posedge clk_in) begin
    if (rst_in) valid_q <= '0;
    else if (we) valid_q[wr_index] <= 1'b1;
  end

  // Tag and data storage carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign valid = valid_q[rd_index];
  assign hit   = valid && (tag_q[rd_index] == rd_tag);
  assign line  = data_q[rd_index];

endmodule

// File: rtl/instr_cache_sa.sv
// Set-associative instruction cache (1 or 2 ways, LRU), one fetch in flight, line refill on miss.
// Optional hit/miss counters (perf_hits/perf_misses) when ICACHE_PERF_EN is defined.
module instr_cache_sa
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 6,
  parameter int WORD_SEL_WIDTH = 1,
  parameter int WAYS           = 2
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  rdy_in,
  input  logic                                  clear_signal,
  input  logic                                  fetch_signal,
  input  logic [ADDR_WIDTH-1:0]                 fetch_addr,
  output logic                                  fetch_done,
  output logic [31:0]                           fetch_instr,
  output logic                                  mem_signal,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic                                  mem_done,
  input  logic [line_width(WORD_SEL_WIDTH)-1:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                           perf_hits,
  output logic [31:0]                           perf_misses
`endif
);

  localparam int TAG_WIDTH  = tag_width(ADDR_WIDTH, INDEX_WIDTH, WORD_SEL_WIDTH);
  localparam int LINE_WIDTH = line_width(WORD_SEL_WIDTH);
  localparam int OFF        = WORD_SEL_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);

  state_t state_q, state_d;

  logic [INDEX_WIDTH-1:0]    lk_index, req_index;
  logic [TAG_WIDTH-1:0]      lk_tag, req_tag;
  logic [WORD_SEL_WIDTH-1:0] lk_sel, req_sel;
  logic                      victim_q, victim_sel;

  logic [WAYS-1:0]       way_hit, way_valid, way_we;
  logic [LINE_WIDTH-1:0] way_line [WAYS];
  logic [LINE_WIDTH-1:0] hit_line;
  logic                  hit, lookup, fill, respond;

  assign lk_sel   = fetch_addr[OFF-1:2];
  assign lk_index = fetch_addr[OFF +: INDEX_WIDTH];
  assign lk_tag   = fetch_addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  // A lookup is skipped in the cycle fetch_done is high so a held request is not answered twice.
  assign lookup  = rdy_in && (state_q == IDLE) && fetch_signal && !fetch_done && !clear_signal;
  assign fill    = rdy_in && (state_q != IDLE) && mem_done;
  assign respond = fill && (state_q == MISS) && !clear_signal;
  assign hit     = |way_hit;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = fill && (victim_q == 1'(w));
    icache_way #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
    ) u_way (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_index(lk_index),
      .rd_tag  (lk_tag),
      .hit     (way_hit[w]),
      .valid   (way_valid[w]),
      .line    (way_line[w]),
      .we      (way_we[w]),
      .wr_index(req_index),
      .wr_tag  (req_tag),
      .wr_line (mem_data)
    );
  end

  always_comb begin
    hit_line = way_line[0];
    if (WAYS == 2 && way_hit[WAYS-1]) hit_line = way_line[WAYS-1];
  end

  if (WAYS == 2) begin : g_lru
    // lru_q[set] names the least-recently-used way of that set.
    logic [(1<<INDEX_WIDTH)-1:0] lru_q;
    logic                        hit_way;
    assign hit_way = way_hit[1];

    always_ff @(posedge clk_in) begin
      if (rst_in) lru_q <= '0;
      else if (lookup && hit) lru_q[lk_index] <= ~hit_way;
      else if (fill) lru_q[req_index] <= ~victim_q;
    end

    always_comb begin
      victim_sel = lru_q[lk_index];
      if (!way_valid[0]) victim_sel = 1'b0;
      else if (!way_valid[1]) victim_sel = 1'b1;
    end
  end else begin : g_dm
    assign victim_sel = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        IDLE:    if (lookup && !hit) state_d = MISS;
        MISS:    if (mem_done) state_d = IDLE; else if (clear_signal) state_d = DRAIN;
        DRAIN:   if (mem_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_done  <= 1'b0;
      fetch_instr <= '0;
      mem_signal  <= 1'b0;
      mem_addr    <= '0;
      req_index   <= '0;
      req_tag     <= '0;
      req_sel     <= '0;
      victim_q    <= 1'b0;
    end else if (rdy_in) begin
      fetch_done <= 1'b0;
      if (lookup) begin
        req_index <= lk_index;
        req_tag   <= lk_tag;
        req_sel   <= lk_sel;
        if (hit) begin
          fetch_done  <= 1'b1;
          fetch_instr <= hit_line[word_lsb(int'(lk_sel)) +: 32];
        end else begin
          mem_signal <= 1'b1;
          mem_addr   <= fetch_addr & LINE_MASK;
          victim_q   <= victim_sel;
        end
      end
      if (fill) begin
        mem_signal <= 1'b0;
        if (respond) begin
          fetch_done  <= 1'b1;
          fetch_instr <= mem_data[word_lsb(int'(req_sel)) +: 32];
        end
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (lookup) begin
      if (hit) perf_hits <= perf_hits + 32'd1;
      else perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_sa.sv
// Randomised bench for instr_cache_sa (defaults: 2 ways, 64 sets, 2 words/line) against an MRU-list cache model.
module tb_instr_cache_sa;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear_signal, fetch_signal, mem_done;
  logic [31:0] fetch_addr, fetch_instr, mem_addr;
  logic        fetch_done, mem_signal;
  logic [63:0] mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  int checks = 0;
  int errors = 0;
  int n_hit  = 0;
  int n_miss = 0;

  // Per set: resident tags, most recently used first.
  int unsigned mq [64][$];

  instr_cache_sa dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear_signal(clear_signal),
    .fetch_signal(fetch_signal),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_instr (fetch_instr),
    .mem_signal  (mem_signal),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] line_data(input logic [31:0] a);
    logic [31:0] la;
    la = a & ~32'h7;
    if (la == 32'h0000_1000) return 64'h00B00093_00A00013;
    return {la ^ 32'hDEAD_0000, ~la};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [63:0] l;
    l = line_data(a);
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  function automatic bit m_has(input logic [31:0] a);
    int s;
    s = int'(a[8:3]);
    for (int i = 0; i < mq[s].size(); i++)
      if (mq[s][i] == 32'(a[31:9])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_touch(input logic [31:0] a);
    int s;
    s = int'(a[8:3]);
    for (int i = 0; i < mq[s].size(); i++)
      if (mq[s][i] == 32'(a[31:9])) begin
        mq[s].delete(i);
        break;
      end
    mq[s].push_front(32'(a[31:9]));
    if (mq[s].size() > 2) void'(mq[s].pop_back());
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) mq[s].delete();
  endfunction

  // mode 0: normal; 1: flush during refill; 2: flush in the same cycle as mem_done.
  task automatic do_fetch(input logic [31:0] a, input int mode);
    bit h;
    int dly;
    h = m_has(a);
    fetch_signal = 1'b1;
    fetch_addr   = a;
    tick();
    if (h) begin
      n_hit++;
      chk("hit_done", 32'(fetch_done), 32'd1);
      chk("hit_instr", fetch_instr, exp_word(a));
      chk("hit_nomem", 32'(mem_signal), 32'd0);
      m_touch(a);
      if ($urandom_range(1) == 1) begin
        tick();
        chk("b2b_done", 32'(fetch_done), 32'd0);
        chk("b2b_mem", 32'(mem_signal), 32'd0);
      end
      fetch_signal = 1'b0;
    end else begin
      n_miss++;
      chk("miss_req", 32'(mem_signal), 32'd1);
      chk("miss_addr", mem_addr, a & ~32'h7);
      chk("miss_nodone", 32'(fetch_done), 32'd0);
      if (mode == 1) begin
        clear_signal = 1'b1;
        fetch_signal = 1'b0;
        tick();
        clear_signal = 1'b0;
        chk("drain_req", 32'(mem_signal), 32'd1);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        tick();
        chk("wait_req", 32'(mem_signal), 32'd1);
        chk("wait_nodone", 32'(fetch_done), 32'd0);
      end
      mem_done = 1'b1;
      mem_data = line_data(a);
      if (mode == 2) begin
        clear_signal = 1'b1;
        fetch_signal = 1'b0;
      end
      tick();
      mem_done     = 1'b0;
      clear_signal = 1'b0;
      fetch_signal = 1'b0;
      chk("fill_done", 32'(fetch_done), (mode == 0) ? 32'd1 : 32'd0);
      if (mode == 0) chk("fill_instr", fetch_instr, exp_word(a));
      chk("fill_mem", 32'(mem_signal), 32'd0);
      m_touch(a);
    end
    tick();
    chk("single_pulse", 32'(fetch_done), 32'd0);
  endtask

  task automatic idle_clear(input logic [31:0] a);
    fetch_signal = 1'b1;
    fetch_addr   = a;
    clear_signal = 1'b1;
    tick();
    chk("iclr_done", 32'(fetch_done), 32'd0);
    chk("iclr_mem", 32'(mem_signal), 32'd0);
    clear_signal = 1'b0;
    fetch_signal = 1'b0;
    tick();
  endtask

  task automatic check_perf();
`ifdef ICACHE_PERF_EN
    chk("perf_hits", perf_hits, 32'(n_hit));
    chk("perf_misses", perf_misses, 32'(n_miss));
`endif
  endtask

  initial begin
    logic [31:0] a;
    int r;
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; fetch_signal = 1'b0;
    fetch_addr = '0; mem_done = 1'b0; mem_data = '0;
    m_clear();
    repeat (2) tick();
    rst_in = 1'b0;
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_mem", 32'(mem_signal), 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    check_perf();

    // Cold miss, hit, same-set conflict with LRU eviction.
    do_fetch(32'h0000_1004, 0);
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1200, 0);
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1400, 0);
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1200, 0);

    // Flush during refill still fills the line.
    do_fetch(32'h0000_1804, 1);
    do_fetch(32'h0000_1804, 0);

    // rdy_in low around mem_done: response delayed, exactly one pulse.
    a = 32'h0000_2008;
    fetch_signal = 1'b1;
    fetch_addr   = a;
    tick();
    n_miss++;
    chk("rdy_req", 32'(mem_signal), 32'd1);
    tick();
    mem_done = 1'b1;
    mem_data = line_data(a);
    rdy_in   = 1'b0;
    repeat (4) begin
      tick();
      chk("rdy_hold_done", 32'(fetch_done), 32'd0);
      chk("rdy_hold_mem", 32'(mem_signal), 32'd1);
    end
    rdy_in = 1'b1;
    tick();
    chk("rdy_done", 32'(fetch_done), 32'd1);
    chk("rdy_instr", fetch_instr, exp_word(a));
    mem_done = 1'b0;
    fetch_signal = 1'b0;
    m_touch(a);
    tick();
    chk("rdy_one_pulse", 32'(fetch_done), 32'd0);

    // Randomised traffic over a small address pool to force hits and conflicts.
    for (int k = 0; k < 200; k++) begin
      a = (32'($urandom_range(8, 12)) << 9) | (32'($urandom_range(0, 1)) << 3) |
          (32'($urandom_range(0, 1)) << 2);
      r = $urandom_range(0, 9);
      if (r == 0) idle_clear(a);
      else do_fetch(a, (r == 1) ? 1 : (r == 2) ? 2 : 0);
    end
    check_perf();

    // Reset during a refill.
    fetch_signal = 1'b1;
    fetch_addr   = 32'h0000_3000;
    tick();
    chk("rmid_req", 32'(mem_signal), 32'd1);
    rst_in = 1'b1;
    fetch_signal = 1'b0;
    tick();
    rst_in = 1'b0;
    chk("rmid_mem", 32'(mem_signal), 32'd0);
    chk("rmid_maddr", mem_addr, 32'd0);
    chk("rmid_done", 32'(fetch_done), 32'd0);
    m_clear();
    n_hit  = 0;
    n_miss = 0;
    check_perf();
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1000, 0);
    check_perf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
